// File: rtl/pcm_frame_packer_if.sv
// Byte-wide write port into the TX FIFO. The packer is the master: it drives
// the write strobe and byte, and the FIFO side returns its full flag.
interface pcm_frame_packer_if;
  logic       wr_en;
  logic [7:0] data;
  logic       full;

  modport master (output wr_en, output data, input full);
  modport slave  (input wr_en, input data, output full);
endinterface

// File: rtl/pcm_frame_packer.sv
// Multi-channel PCM frame packer: captures one frame of NUM_CHANNELS samples on
// a strobe and serialises it one byte per cycle into the TX FIFO, optionally
// preceded by a sync word every SYNC_PERIOD frames. Strobes that arrive while a
// frame is still being written are discarded and counted (saturating).
module pcm_frame_packer #(
  parameter int          NUM_CHANNELS = 2,
  parameter int          DATA_SIZE    = 24,
  parameter int          OUT_BYTES    = 3,
  parameter int          MSB_FIRST    = 0,
  parameter int          SYNC_PERIOD  = 126,
  parameter int          SYNC_BYTES   = 3,
  parameter logic [31:0] SYNC_WORD    = 32'h00AAFF00,
  parameter int          DROP_W       = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable_i,
  input  logic                              sample_valid_i,
  input  logic [NUM_CHANNELS*DATA_SIZE-1:0] sample_data_i,
  output logic                              sample_ready_o,
  pcm_frame_packer_if.master                fifo,
  output logic                              busy_o,
  output logic [DROP_W-1:0]                 drop_count_o,
  output logic                              sync_sent_o
);

  localparam int OW    = 8 * OUT_BYTES;
  localparam int CAP_W = NUM_CHANNELS * OW;
  localparam int SHIFT = (DATA_SIZE > OW) ? DATA_SIZE - OW : 0;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FC_W  = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

  localparam logic [1:0]        LAST_DBYTE = 2'(OUT_BYTES - 1);
  localparam logic [1:0]        LAST_SBYTE = 2'(SYNC_BYTES - 1);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CHANNELS - 1);
  localparam logic [FC_W-1:0]   LAST_FC    = FC_W'((SYNC_PERIOD > 0) ? SYNC_PERIOD - 1 : 0);
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_q, byte_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [CAP_W-1:0]    cap_q, cap_d;

  logic                wr_en;
  logic                sync_sent;
  logic [1:0]          d_sel;
  logic [1:0]          s_sel;
  logic [7:0]          data_byte;
  logic [7:0]          sync_byte;
  logic [7:0]          out_byte;

  // Narrow samples are sign-extended to the output width; wide samples keep
  // their most significant bits.
  function automatic logic [OW-1:0] fmt_sample(input logic [DATA_SIZE-1:0] s);
    logic signed [DATA_SIZE-1:0] s_signed;
    s_signed = s;
    if (OW >= DATA_SIZE) return OW'(s_signed);
    else                 return OW'(s >> SHIFT);
  endfunction

  // State, indices, frame counter, drop counter and capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      ch_q    <= '0;
      fc_q    <= '0;
      drop_q  <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      ch_q    <= ch_d;
      fc_q    <= fc_d;
      drop_q  <= drop_d;
      cap_q   <= cap_d;
    end
  end

  // Frame acceptance / drop accounting and byte sequencing; indices only move
  // on cycles where a byte actually enters the FIFO.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    ch_d      = ch_q;
    fc_d      = fc_q;
    drop_d    = drop_q;
    cap_d     = cap_q;
    sync_sent = 1'b0;
    wr_en     = (state_q != ST_IDLE) & ~fifo.full;

    if (sample_valid_i && enable_i) begin
      if (state_q == ST_IDLE) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          cap_d[c*OW +: OW] = fmt_sample(sample_data_i[c*DATA_SIZE +: DATA_SIZE]);
        end
        byte_d  = '0;
        ch_d    = '0;
        state_d = (SYNC_PERIOD != 0 && fc_q == '0) ? ST_SYNC : ST_DATA;
      end else if (drop_q != DROP_MAX) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end

    case (state_q)
      ST_SYNC: begin
        if (wr_en) begin
          if (byte_q == LAST_SBYTE) begin
            byte_d    = '0;
            state_d   = ST_DATA;
            sync_sent = 1'b1;
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (wr_en) begin
          if (byte_q == LAST_DBYTE) begin
            byte_d = '0;
            if (ch_q == LAST_CH) begin
              state_d = ST_IDLE;
              fc_d    = (fc_q == LAST_FC) ? '0 : fc_q + FC_W'(1);
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output byte selection from the registered state, honouring byte order.
  always_comb begin
    d_sel     = (MSB_FIRST != 0) ? (LAST_DBYTE - byte_q) : byte_q;
    s_sel     = (MSB_FIRST != 0) ? (LAST_SBYTE - byte_q) : byte_q;
    data_byte = 8'(cap_q >> (32'(ch_q) * OW + 32'(d_sel) * 8));
    sync_byte = 8'(SYNC_WORD >> (32'(s_sel) * 8));
    out_byte  = 8'h00;
    case (state_q)
      ST_SYNC: out_byte = sync_byte;
      ST_DATA: out_byte = data_byte;
      default: out_byte = 8'h00;
    endcase
  end

  assign fifo.wr_en     = wr_en;
  assign fifo.data      = out_byte;
  assign busy_o         = (state_q != ST_IDLE);
  assign sample_ready_o = (state_q == ST_IDLE);
  assign drop_count_o   = drop_q;
  assign sync_sent_o    = sync_sent;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Testbench for pcm_frame_packer: a default-parameter instance checked every
// cycle against a queue-based reference model, plus two narrow single-channel
// instances for sample formatting and drop saturation.
module tb_pcm_frame_packer;

  localparam int          T_NC  = 2;
  localparam int          T_DS  = 24;
  localparam int          T_OB  = 3;
  localparam int          T_MSB = 0;
  localparam int          T_SP  = 126;
  localparam int          T_SB  = 3;
  localparam logic [31:0] T_SW  = 32'h00AAFF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Default instance
  logic        en0, valid0;
  logic [47:0] data0;
  logic        ready0, busy0, sync0;
  logic [7:0]  drop0;
  pcm_frame_packer_if f0();

  pcm_frame_packer #(
    .NUM_CHANNELS(T_NC), .DATA_SIZE(T_DS), .OUT_BYTES(T_OB), .MSB_FIRST(T_MSB),
    .SYNC_PERIOD(T_SP), .SYNC_BYTES(T_SB), .SYNC_WORD(T_SW), .DROP_W(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(en0), .sample_valid_i(valid0),
    .sample_data_i(data0), .sample_ready_o(ready0), .fifo(f0),
    .busy_o(busy0), .drop_count_o(drop0), .sync_sent_o(sync0)
  );

  // Narrow instances sharing one strobe
  logic        en12, valid12;
  logic [15:0] data1;
  logic [23:0] data2;
  logic        ready1, busy1, sync1, ready2, busy2, sync2;
  logic [1:0]  drop1;
  logic [7:0]  drop2;
  pcm_frame_packer_if f1();
  pcm_frame_packer_if f2();

  pcm_frame_packer #(
    .NUM_CHANNELS(1), .DATA_SIZE(16), .OUT_BYTES(3), .MSB_FIRST(1),
    .SYNC_PERIOD(0), .SYNC_BYTES(3), .SYNC_WORD(T_SW), .DROP_W(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(en12), .sample_valid_i(valid12),
    .sample_data_i(data1), .sample_ready_o(ready1), .fifo(f1),
    .busy_o(busy1), .drop_count_o(drop1), .sync_sent_o(sync1)
  );

  pcm_frame_packer #(
    .NUM_CHANNELS(1), .DATA_SIZE(24), .OUT_BYTES(2), .MSB_FIRST(1),
    .SYNC_PERIOD(0), .SYNC_BYTES(3), .SYNC_WORD(T_SW), .DROP_W(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable_i(en12), .sample_valid_i(valid12),
    .sample_data_i(data2), .sample_ready_o(ready2), .fifo(f2),
    .busy_o(busy2), .drop_count_o(drop2), .sync_sent_o(sync2)
  );

  typedef struct { logic [7:0] b; bit last_sync; } mbyte_t;
  typedef struct { logic [7:0] b; int c; bit s; } cap_t;
  typedef struct { logic [23:0] c0; logic [23:0] c1; int n; logic [71:0] b; } vec_t;

  mbyte_t mq[$];
  cap_t   cap[$];
  int     m_frames = 0;
  int     m_drop   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expand an accepted frame into its byte sequence.
  function automatic void model_accept(input logic [47:0] d);
    mbyte_t e;
    longint s;
    int     pos;
    if (T_SP != 0 && (m_frames % T_SP) == 0) begin
      for (int i = 0; i < T_SB; i++) begin
        pos = (T_MSB != 0) ? T_SB - 1 - i : i;
        e.b = 8'(T_SW >> (8 * pos));
        e.last_sync = (i == T_SB - 1);
        mq.push_back(e);
      end
    end
    for (int c = 0; c < T_NC; c++) begin
      s = longint'((64'(d) >> (c * T_DS)) & ((64'd1 << T_DS) - 64'd1));
      if (8 * T_OB >= T_DS) begin
        if (s >= (64'sd1 <<< (T_DS - 1))) s = s - (64'sd1 <<< T_DS);
      end else begin
        s = s >>> (T_DS - 8 * T_OB);
      end
      for (int i = 0; i < T_OB; i++) begin
        pos = (T_MSB != 0) ? T_OB - 1 - i : i;
        e.b = 8'(s >>> (8 * pos));
        e.last_sync = 1'b0;
        mq.push_back(e);
      end
    end
    m_frames++;
  endfunction

  // Per-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    bit     busy_m, ew;
    mbyte_t h;
    cap_t   ce;
    if (!rst_n) begin
      mq.delete();
      m_frames = 0;
      m_drop   = 0;
      chk("rst wr_en", 32'(f0.wr_en), 0);
      chk("rst busy", 32'(busy0), 0);
    end else begin
      busy_m = (mq.size() != 0);
      ew     = busy_m && !f0.full;
      chk("wr_en", 32'(f0.wr_en), 32'(ew));
      chk("busy", 32'(busy0), 32'(busy_m));
      chk("ready", 32'(ready0), 32'(!busy_m));
      chk("drop_count", 32'(drop0), 32'(m_drop));
      if (ew) begin
        h = mq.pop_front();
        chk("data", 32'(f0.data), 32'(h.b));
        chk("sync_sent", 32'(sync0), 32'(h.last_sync));
      end else begin
        chk("sync_sent quiet", 32'(sync0), 0);
      end
      if (f0.wr_en) begin
        ce.b = f0.data; ce.c = cyc; ce.s = sync0;
        cap.push_back(ce);
      end
      if (valid0 && en0) begin
        if (busy_m) begin
          if (m_drop < 255) m_drop++;
        end else begin
          model_accept(data0);
        end
      end
    end
  end

  task automatic strobe0(input logic [47:0] d);
    data0  = d;
    valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
  endtask

  task automatic wait_idle0(input bit rnd);
    int k = 0;
    while (!(ready0 && mq.size() == 0) && k < 300) begin
      if (rnd) f0.full = ($urandom_range(3) == 0);
      tick();
      k++;
    end
    f0.full = 1'b0;
    if (k >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_idle0: frame still open after %0d cycles, required idle", k);
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[3];
    int          stb;
    int          nsync;
    int          sidx[$];
    logic [23:0] e1;
    logic [15:0] e2;

    tbl[0] = '{24'h123456, 24'hABCDEF, 9, 72'h00FFAA563412EFCDAB};
    tbl[1] = '{24'h000001, 24'hFFFFFF, 6, 72'h010000FFFFFF000000};
    tbl[2] = '{24'h800000, 24'h7FFFFF, 6, 72'h000080FFFF7F000000};

    rst_n = 1'b0; en0 = 1'b1; valid0 = 1'b0; data0 = '0; f0.full = 1'b0;
    en12 = 1'b1; valid12 = 1'b0; data1 = '0; data2 = '0; f1.full = 1'b0; f2.full = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Idle outputs straight after reset
    @(negedge clk);
    chk("reset wr_en", 32'(f0.wr_en), 0);
    chk("reset data", 32'(f0.data), 0);
    chk("reset busy", 32'(busy0), 0);
    chk("reset ready", 32'(ready0), 1);
    chk("reset drop", 32'(drop0), 0);
    chk("reset sync_sent", 32'(sync0), 0);
    tick();

    // Table of directed frames: bytes, cycle stamps and sync pulse position
    for (int i = 0; i < 3; i++) begin
      cap.delete();
      stb = cyc;
      strobe0({tbl[i].c1, tbl[i].c0});
      wait_idle0(1'b0);
      chk("tbl length", 32'(cap.size()), 32'(tbl[i].n));
      for (int j = 0; j < tbl[i].n && j < cap.size(); j++) begin
        chk("tbl byte", 32'(cap[j].b), 32'(tbl[i].b[71-8*j -: 8]));
        chk("tbl cycle", 32'(cap[j].c), 32'(stb + 1 + j));
        chk("tbl sync", 32'(cap[j].s), 32'(tbl[i].n == 9 && j == 2));
      end
      tick();
    end
    chk("first frames drop", 32'(drop0), 0);

    // 127 random frames with random FIFO stalls: sync before frames 0 and 126
    rst_pulse();
    cap.delete();
    for (int f = 0; f < 127; f++) begin
      strobe0({16'($urandom), $urandom});
      wait_idle0(1'b1);
    end
    chk("127 frames byte count", 32'(cap.size()), 127 * 6 + 2 * 3);
    nsync = 0;
    sidx.delete();
    foreach (cap[j]) if (cap[j].s) begin nsync++; sidx.push_back(j); end
    chk("127 frames sync pulses", 32'(nsync), 2);
    if (sidx.size() == 2) begin
      chk("sync pulse 0 index", 32'(sidx[0]), 2);
      chk("sync pulse 1 index", 32'(sidx[1]), 761);
    end

    // FIFO full for 5 cycles on the second data byte
    rst_pulse();
    cap.delete();
    stb = cyc;
    strobe0({24'hABCDEF, 24'h123456});
    repeat (4) tick();
    f0.full = 1'b1;
    repeat (5) tick();
    f0.full = 1'b0;
    wait_idle0(1'b0);
    chk("stall length", 32'(cap.size()), 9);
    if (cap.size() == 9) begin
      for (int j = 0; j < 9; j++) chk("stall byte", 32'(cap[j].b), 32'(tbl[0].b[71-8*j -: 8]));
      chk("stall before", 32'(cap[3].c), 32'(stb + 4));
      chk("stall resume", 32'(cap[4].c), 32'(stb + 10));
      chk("stall last", 32'(cap[8].c), 32'(stb + 14));
    end

    // Strobes during a frame are dropped and counted; disabled strobes ignored
    rst_pulse();
    cap.delete();
    strobe0({24'hABCDEF, 24'h123456});
    tick();
    strobe0(48'h111111222222);
    tick();
    strobe0(48'h333333444444);
    strobe0(48'h555555666666);
    strobe0(48'h777777888888);
    wait_idle0(1'b0);
    chk("drop count 4", 32'(drop0), 4);
    chk("drop frame length", 32'(cap.size()), 9);
    en0 = 1'b0;
    strobe0(48'h999999AAAAAA);
    tick();
    en0 = 1'b1;
    chk("disabled strobe drop", 32'(drop0), 4);
    chk("disabled strobe busy", 32'(busy0), 0);

    // Reset after the 4th byte of a frame
    cap.delete();
    strobe0({24'hABCDEF, 24'h123456});
    repeat (4) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset wr_en", 32'(f0.wr_en), 0);
    chk("midreset data", 32'(f0.data), 0);
    chk("midreset busy", 32'(busy0), 0);
    chk("midreset ready", 32'(ready0), 1);
    chk("midreset drop", 32'(drop0), 0);
    chk("midreset sync_sent", 32'(sync0), 0);
    chk("midreset bytes written", 32'(cap.size()), 4);
    tick();
    rst_n = 1'b1;
    tick();
    cap.delete();
    strobe0({24'hABCDEF, 24'h123456});
    wait_idle0(1'b0);
    chk("post reset length", 32'(cap.size()), 9);
    if (cap.size() == 9) begin
      for (int j = 0; j < 3; j++) chk("post reset sync byte", 32'(cap[j].b), 32'(tbl[0].b[71-8*j -: 8]));
    end

    // Random strobes, enables and stalls against the model
    for (int k = 0; k < 600; k++) begin
      valid0  = ($urandom_range(3) == 0);
      en0     = ($urandom_range(7) != 0);
      f0.full = ($urandom_range(3) == 0);
      data0   = {16'($urandom), $urandom};
      tick();
    end
    valid0 = 1'b0;
    en0 = 1'b1;
    f0.full = 1'b0;
    wait_idle0(1'b0);

    // Narrow instances: sign extension, truncation, MSB-first order
    e1 = 24'hFF8001;
    e2 = 16'h1234;
    data1 = 16'h8001;
    data2 = 24'h123456;
    valid12 = 1'b1;
    tick();
    valid12 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("sext wr_en", 32'(f1.wr_en), 1);
      chk("sext byte", 32'(f1.data), 32'(e1[23-8*j -: 8]));
      if (j < 2) begin
        chk("trunc wr_en", 32'(f2.wr_en), 1);
        chk("trunc byte", 32'(f2.data), 32'(e2[15-8*j -: 8]));
      end else begin
        chk("trunc done", 32'(f2.wr_en), 0);
      end
    end
    @(negedge clk);
    chk("sext done", 32'(f1.wr_en), 0);

    // Continuous strobe: drop counter saturation on the 2-bit instance
    tick();
    valid12 = 1'b1;
    repeat (8) tick();
    valid12 = 1'b0;
    repeat (6) tick();
    chk("drop saturate w2", 32'(drop1), 3);
    chk("drop count w8", 32'(drop2), 5);
    chk("narrow ready1", 32'(ready1), 1);
    chk("narrow busy1", 32'(busy1), 0);
    chk("narrow sync1", 32'(sync1), 0);
    chk("narrow ready2", 32'(ready2), 1);
    chk("narrow busy2", 32'(busy2), 0);
    chk("narrow sync2", 32'(sync2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
